// File: rtl/pipe_ctrl_if.sv
// Instruction-fetch bus between the pipeline sequencer and instruction memory.
// The sequencer is the master: it issues the request and samples the response.
interface pipe_ctrl_if;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;

    modport master (
        output ireq_valid,
        output ireq_addr,
        input  iresp_data_ok,
        input  iresp_data
    );

    modport slave (
        input  ireq_valid,
        input  ireq_addr,
        output iresp_data_ok,
        output iresp_data
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: owns the PC and instruction fetch, buffers one
// fetched instruction while the front end is frozen, and drives stage stall/flush.
module pipe_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    pipe_ctrl_if.master ibus,
    output logic        f_valid,
    output logic [95:0] f_data,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        d_use_rs1,
    input  logic        d_use_rs2,
    input  logic        e_valid,
    input  logic        e_memread,
    input  logic [4:0]  e_dst,
    input  logic        m_memop,
    input  logic        dbus_data_ok,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_e,
    output logic        flush_w,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        INIT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [95:0] hold_buf;
    logic [95:0] hold_buf_nxt;
    logic        dmem_stall;
    logic        load_use;
    logic        stall_any;

    always_comb begin
        dmem_stall = m_memop & ~dbus_data_ok;
        load_use   = e_valid & e_memread & (e_dst != 5'd0) &
                     ((d_use_rs1 & (d_rs1 == e_dst)) |
                      (d_use_rs2 & (d_rs2 == e_dst)));
        stall_any  = dmem_stall | load_use;
    end

    // Outputs are forced to zero while reset is held; the FSM state itself is
    // reset on the edge, so gating here covers the first reset cycle too.
    always_comb begin
        ibus.ireq_valid = 1'b0;
        ibus.ireq_addr  = reset ? pc : PC_RESET;
        f_valid         = 1'b0;
        f_data          = '0;
        stall_f         = 1'b0;
        stall_d         = 1'b0;
        stall_e         = 1'b0;
        stall_m         = 1'b0;
        flush_e         = 1'b0;
        flush_w         = 1'b0;
        state_nxt       = state;
        pc_nxt          = pc;
        hold_buf_nxt    = hold_buf;

        if (reset) begin
            stall_f = stall_any;
            stall_d = stall_any;
            stall_e = dmem_stall;
            stall_m = dmem_stall;
            flush_e = load_use & ~dmem_stall;
            flush_w = dmem_stall;

            case (state)
                INIT: begin
                    state_nxt = FETCH;
                end
                FETCH: begin
                    ibus.ireq_valid = 1'b1;
                    f_valid         = ibus.iresp_data_ok;
                    f_data          = {ibus.iresp_data, pc};
                    if (ibus.iresp_data_ok) begin
                        if (!stall_any) begin
                            pc_nxt = pc + 64'd4;
                        end else begin
                            hold_buf_nxt = {ibus.iresp_data, pc};
                            state_nxt    = HOLD;
                        end
                    end
                end
                HOLD: begin
                    f_valid = 1'b1;
                    f_data  = hold_buf;
                    if (!stall_any) begin
                        pc_nxt    = pc + 64'd4;
                        state_nxt = FETCH;
                    end
                end
                default: begin
                    state_nxt = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= INIT;
            pc        <= PC_RESET;
            hold_buf  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            hold_buf <= hold_buf_nxt;
            if (stall_any) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: hazard vector table, directed fetch/stall/reset sequences,
// and random stimulus checked against a queue-based model of the fetch stream.
module tb_pipe_ctrl;

    localparam logic [63:0] PC0 = 64'h8000_0000;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        ev;
        logic        emr;
        logic [4:0]  edst;
        logic        mop;
        logic        dok;
        logic        iok;
        logic [31:0] idata;
    } in_t;

    typedef struct {
        in_t  v;
        logic sf;
        logic se;
        logic fe;
        logic fw;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        f_valid;
    logic [95:0] f_data;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic        d_use_rs1;
    logic        d_use_rs2;
    logic        e_valid;
    logic        e_memread;
    logic [4:0]  e_dst;
    logic        m_memop;
    logic        dbus_data_ok;
    logic        stall_f;
    logic        stall_d;
    logic        stall_e;
    logic        stall_m;
    logic        flush_e;
    logic        flush_w;
    logic [31:0] stall_cnt;

    pipe_ctrl_if ibus_if ();

    pipe_ctrl #(.PC_RESET(PC0)) dut (
        .clk          (clk),
        .reset        (reset),
        .ibus         (ibus_if),
        .f_valid      (f_valid),
        .f_data       (f_data),
        .d_rs1        (d_rs1),
        .d_rs2        (d_rs2),
        .d_use_rs1    (d_use_rs1),
        .d_use_rs2    (d_use_rs2),
        .e_valid      (e_valid),
        .e_memread    (e_memread),
        .e_dst        (e_dst),
        .m_memop      (m_memop),
        .dbus_data_ok (dbus_data_ok),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned n_deadbeef = 0;

    // Model: next PC not yet accepted by F/D, instructions returned but not yet
    // accepted, edges since reset release, and the stall counter.
    logic [63:0] m_pc = PC0;
    logic [95:0] m_q[$];
    int unsigned m_since = 0;
    logic [31:0] m_cnt = '0;
    logic        m_known = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [1:0] haz(input in_t v);
        logic dm;
        logic lu;
        dm = v.mop && !v.dok;
        lu = v.ev && v.emr && v.edst != 0 &&
             ((v.u1 && v.rs1 == v.edst) || (v.u2 && v.rs2 == v.edst));
        return {dm, lu};
    endfunction

    task automatic apply(input logic rst, input in_t v);
        logic [1:0] h;
        logic       sf;
        @(negedge clk);
        reset                 = rst;
        d_rs1                 = v.rs1;
        d_rs2                 = v.rs2;
        d_use_rs1             = v.u1;
        d_use_rs2             = v.u2;
        e_valid               = v.ev;
        e_memread             = v.emr;
        e_dst                 = v.edst;
        m_memop               = v.mop;
        dbus_data_ok          = v.dok;
        ibus_if.iresp_data_ok = v.iok;
        ibus_if.iresp_data    = v.idata;
        #1;
        h  = haz(v);
        sf = h[1] | h[0];
        if (m_known) chk("stall_cnt", stall_cnt, m_cnt);
        if (!rst) begin
            chk("rst_ireq_valid", ibus_if.ireq_valid, 0);
            chk("rst_ireq_addr", ibus_if.ireq_addr, PC0);
            chk("rst_f_valid", f_valid, 0);
            chk("rst_f_data", f_data, 0);
            chk("rst_stalls", {stall_f, stall_d, stall_e, stall_m, flush_e, flush_w}, 0);
        end else begin
            chk("stall_f", stall_f, sf);
            chk("stall_d", stall_d, sf);
            chk("stall_e", stall_e, h[1]);
            chk("stall_m", stall_m, h[1]);
            chk("flush_e", flush_e, h[0] & ~h[1]);
            chk("flush_w", flush_w, h[1]);
            if (m_since == 0) begin
                chk("init_ireq_valid", ibus_if.ireq_valid, 0);
                chk("init_f_valid", f_valid, 0);
            end else if (m_q.size() > 0) begin
                chk("hold_ireq_valid", ibus_if.ireq_valid, 0);
                chk("hold_f_valid", f_valid, 1);
                chk("hold_f_data", f_data, m_q[0]);
            end else begin
                chk("fetch_ireq_valid", ibus_if.ireq_valid, 1);
                chk("fetch_ireq_addr", ibus_if.ireq_addr, m_pc);
                chk("fetch_f_valid", f_valid, v.iok);
                chk("fetch_f_data", f_data, {v.idata, m_pc});
            end
            if (f_valid && !stall_f && f_data[95:64] == 32'hDEAD_BEEF) n_deadbeef++;
        end
    endtask

    task automatic edge_update(input logic rst, input in_t v);
        logic [1:0] h;
        logic       sf;
        @(posedge clk);
        h  = haz(v);
        sf = h[1] | h[0];
        if (!rst) begin
            m_pc    = PC0;
            m_q.delete();
            m_since = 0;
            m_cnt   = '0;
            m_known = 1'b1;
        end else begin
            if (sf) m_cnt = m_cnt + 32'd1;
            if (m_since > 0) begin
                if (m_q.size() > 0) begin
                    if (!sf) begin
                        void'(m_q.pop_front());
                        m_pc = m_pc + 64'd4;
                    end
                end else if (v.iok) begin
                    if (!sf) m_pc = m_pc + 64'd4;
                    else m_q.push_back({v.idata, m_pc});
                end
            end
            if (m_since < 2) m_since++;
        end
    endtask

    task automatic cycle(input logic rst, input in_t v);
        apply(rst, v);
        edge_update(rst, v);
    endtask

    in_t idle;
    in_t v;
    vec_t tbl[10];
    logic [31:0] c0;

    task automatic do_reset();
        cycle(0, idle);
        cycle(0, idle);
    endtask

    initial begin
        idle = '{rs1: 0, rs2: 0, u1: 0, u2: 0, ev: 0, emr: 0, edst: 0,
                 mop: 0, dok: 0, iok: 1, idata: 32'h0000_0013};

        // Reset, then zero-wait fetch stream
        do_reset();
        apply(1, idle);
        chk("first_init_ireq_valid", ibus_if.ireq_valid, 0);
        edge_update(1, idle);
        for (int unsigned k = 0; k < 3; k++) begin
            apply(1, idle);
            chk("seq_addr", ibus_if.ireq_addr, PC0 + 64'(4 * k));
            chk("seq_f_valid", f_valid, 1);
            chk("seq_stall_cnt", stall_cnt, 0);
            edge_update(1, idle);
        end

        // Load-use: one bubble, then clear
        v = idle;
        v.ev = 1; v.emr = 1; v.edst = 5; v.u1 = 1; v.rs1 = 5;
        apply(1, v);
        chk("lu_stall_f", stall_f, 1);
        chk("lu_flush_e", flush_e, 1);
        c0 = stall_cnt;
        edge_update(1, v);
        v.ev = 0; v.emr = 0;
        apply(1, v);
        chk("lu_cnt_inc", stall_cnt, c0 + 32'd1);
        chk("lu_cleared", stall_f, 0);
        edge_update(1, v);

        // x0 never hazards
        v = idle;
        v.ev = 1; v.emr = 1; v.edst = 0; v.u1 = 1; v.rs1 = 0;
        apply(1, v);
        chk("x0_stall_f", stall_f, 0);
        chk("x0_flush_e", flush_e, 0);
        edge_update(1, v);

        // Dmem wait overrides load-use for 3 cycles
        v = idle;
        v.ev = 1; v.emr = 1; v.edst = 5; v.u2 = 1; v.rs2 = 5; v.mop = 1; v.dok = 0;
        apply(1, v);
        c0 = stall_cnt;
        edge_update(1, v);
        for (int unsigned k = 1; k < 3; k++) cycle(1, v);
        v.dok = 1;
        apply(1, v);
        chk("dm_cnt_plus3", stall_cnt, c0 + 32'd3);
        chk("dm_done_flush_e", flush_e, 1);
        chk("dm_done_stall_e", stall_e, 0);
        edge_update(1, v);

        // Hazard vector table
        tbl[0] = '{'{5, 0, 1, 0, 1, 1, 5, 0, 0, 1, 32'h13}, 1, 0, 1, 0};
        tbl[1] = '{'{0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 32'h13}, 0, 0, 0, 0};
        tbl[2] = '{'{3, 7, 0, 1, 1, 1, 7, 0, 0, 1, 32'h13}, 1, 0, 1, 0};
        tbl[3] = '{'{7, 3, 0, 1, 1, 1, 7, 0, 0, 1, 32'h13}, 0, 0, 0, 0};
        tbl[4] = '{'{5, 0, 1, 0, 1, 0, 5, 0, 0, 1, 32'h13}, 0, 0, 0, 0};
        tbl[5] = '{'{5, 0, 1, 0, 0, 1, 5, 0, 0, 1, 32'h13}, 0, 0, 0, 0};
        tbl[6] = '{'{1, 2, 1, 1, 0, 0, 0, 1, 0, 1, 32'h13}, 1, 1, 0, 1};
        tbl[7] = '{'{5, 0, 1, 0, 1, 1, 5, 1, 0, 1, 32'h13}, 1, 1, 0, 1};
        tbl[8] = '{'{5, 0, 1, 0, 1, 1, 5, 1, 1, 1, 32'h13}, 1, 0, 1, 0};
        tbl[9] = '{'{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h13}, 0, 0, 0, 0};
        for (int unsigned i = 0; i < 10; i++) begin
            apply(1, tbl[i].v);
            chk("tbl_stall_f", stall_f, tbl[i].sf);
            chk("tbl_stall_e", stall_e, tbl[i].se);
            chk("tbl_flush_e", flush_e, tbl[i].fe);
            chk("tbl_flush_w", flush_w, tbl[i].fw);
            edge_update(1, tbl[i].v);
        end

        // Fetch returns while frozen: held exactly once, no new request in HOLD
        do_reset();
        n_deadbeef = 0;
        for (int unsigned k = 0; k < 5; k++) cycle(1, idle);
        v = idle;
        v.idata = 32'hDEAD_BEEF; v.mop = 1; v.dok = 0;
        apply(1, v);
        chk("hold_req_addr", ibus_if.ireq_addr, 64'h8000_0010);
        edge_update(1, v);
        v.iok = 0;
        for (int unsigned k = 0; k < 2; k++) begin
            apply(1, v);
            chk("hold_no_req", ibus_if.ireq_valid, 0);
            chk("hold_buf", f_data, {32'hDEAD_BEEF, 64'h8000_0010});
            edge_update(1, v);
        end
        v.mop = 0;
        apply(1, v);
        chk("hold_release_fv", f_valid, 1);
        chk("hold_release_data", f_data, {32'hDEAD_BEEF, 64'h8000_0010});
        edge_update(1, v);
        apply(1, idle);
        chk("after_hold_addr", ibus_if.ireq_addr, 64'h8000_0014);
        edge_update(1, idle);
        chk("deadbeef_once", n_deadbeef, 1);

        // Reset during a pending request
        do_reset();
        for (int unsigned k = 0; k < 9; k++) cycle(1, idle);
        v = idle;
        v.iok = 0;
        apply(1, v);
        chk("pend_addr", ibus_if.ireq_addr, 64'h8000_0020);
        chk("pend_valid", ibus_if.ireq_valid, 1);
        edge_update(1, v);
        apply(0, v);
        chk("mid_rst_ireq_valid", ibus_if.ireq_valid, 0);
        edge_update(0, v);
        cycle(1, idle);
        apply(1, idle);
        chk("restart_addr", ibus_if.ireq_addr, PC0);
        chk("restart_cnt", stall_cnt, 0);
        edge_update(1, idle);

        // Randomized traffic against the model
        for (int unsigned n = 0; n < 3000; n++) begin
            logic r;
            r       = ($urandom_range(0, 99) >= 2);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom_range(0, 1));
            v.u2    = 1'($urandom_range(0, 1));
            v.ev    = 1'($urandom_range(0, 1));
            v.emr   = 1'($urandom_range(0, 1));
            v.edst  = 5'($urandom_range(0, 3));
            v.mop   = ($urandom_range(0, 99) < 30);
            v.dok   = 1'($urandom_range(0, 1));
            v.iok   = ($urandom_range(0, 99) < 60);
            v.idata = $urandom;
            cycle(r, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
